ddr3_burst_mem: RTL and testbench

- Single-clock, command-level DDR3 x16 memory device model. Used in place of one physical DDR3 chip on the PS DDR bus in system-level simulation.
- Decodes ACT/RD/WR/PRE/REF/MRS/NOP commands and tracks open rows per bank.
- Stores data in a 2^MEM_BITS x 16 array and returns BL8 read bursts after a fixed CAS latency.
- Flags protocol violations on a single error pulse output.

---
 rtl/ddr3_burst_mem_if.sv | 36 +++
 rtl/ddr3_burst_mem.sv | 241 ++++++++++++++++++++++++
 tb/tb_ddr3_burst_mem.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_burst_mem_if.sv
// -----------------------------------------------------------------------------
// ddr3_burst_mem_if
// Command/data bus of one DDR3 x16 device as seen by the command-level model.
//   master : memory controller side (drives command strobes, address, write data)
//   slave  : memory device side (drives read data, read-data enable, error pulse)
// Signals:
//   cke, cs_n, ras_n, cas_n, we_n : clock enable and command strobes
//   ba[2:0], addr[14:0]           : bank / row-or-column address
//   dm[1:0], dq_i[15:0]           : write byte mask (1 = masked) and write data
//   dq_o[15:0], dq_oe             : read data and its valid flag
//   err                           : one-cycle pulse on an illegal command
// -----------------------------------------------------------------------------
interface ddr3_burst_mem_if;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [2:0]  ba;
    logic [14:0] addr;
    logic [1:0]  dm;
    logic [15:0] dq_i;
    logic [15:0] dq_o;
    logic        dq_oe;
    logic        err;

    modport master (
        output cke, cs_n, ras_n, cas_n, we_n, ba, addr, dm, dq_i,
        input  dq_o, dq_oe, err
    );

    modport slave (
        input  cke, cs_n, ras_n, cas_n, we_n, ba, addr, dm, dq_i,
        output dq_o, dq_oe, err
    );
endinterface

// File: rtl/ddr3_burst_mem.sv
// -----------------------------------------------------------------------------
// ddr3_burst_mem
// Command-level model of one DDR3 x16 device. Decodes ACT/RD/WR/PRE/REF/MRS,
// tracks the open row of each of the 8 banks, stores data in a 2^MEM_BITS x 16
// array and plays back BL8 read bursts CL clocks after the RD command. Write
// beats are captured CWL..CWL+7 clocks after the WR command. Illegal commands
// are ignored and flagged with a one-cycle err pulse.
//
// Ports:
//   sys_clk : clock, everything sampled on the rising edge
//   sys_rst : synchronous active-high reset (array contents are kept)
//   bus     : ddr3_burst_mem_if.slave (command, address, data, err)
//
// Parameters: MEM_BITS (storage depth log2, upper address bits alias),
//   CL (read latency 1..15), CWL (write latency 1..15), DEBUG (trace hook,
//   no functional effect).
//
// Optional feature: define DDR3_BURST_MEM_DM_EN to honour dm per byte;
// without it every write beat writes both bytes.
// -----------------------------------------------------------------------------
module ddr3_burst_mem #(
    parameter int MEM_BITS = 18,
    parameter int CL       = 5,
    parameter int CWL      = 5,
    parameter int DEBUG    = 0
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    ddr3_burst_mem_if.slave bus
);
    localparam int         DEPTH    = 2 ** MEM_BITS;
    localparam logic [4:0] RD_FIRST = 5'(CL);
    localparam logic [4:0] RD_LAST  = 5'(CL + 7);
    localparam logic [4:0] WR_FIRST = 5'(CWL);
    localparam logic [4:0] WR_LAST  = 5'(CWL + 7);

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_ZQ  = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic {
        ENG_IDLE = 1'b0,
        ENG_BUSY = 1'b1
    } eng_e;

    logic [15:0] mem_q [DEPTH];

    logic [7:0]  bank_open_q, bank_open_d;
    logic [14:0] bank_row_q [8];
    logic [14:0] bank_row_d [8];

    // Each engine counts edges since its command; the tick equals the latency
    // on beat 0. The base holds {ba, row, col[9:3]} captured at the command.
    eng_e        rd_state_q, rd_state_d, wr_state_q, wr_state_d;
    logic [4:0]  rd_tick_q, rd_tick_d, wr_tick_q, wr_tick_d;
    logic [24:0] rd_base_q, rd_base_d, wr_base_q, wr_base_d;

    logic [15:0] dq_o_q, dq_o_d;
    logic        dq_oe_q, dq_oe_d;
    logic        err_q, err_d;

    cmd_e          cmd_s;
    logic          cmd_valid_s;
    logic          rdwr_ok_s;
    logic [4:0]    rd_off_s, wr_off_s;
    logic [27:0]   rd_full_idx_s, wr_full_idx_s;
    logic [MEM_BITS-1:0] wr_idx_s;
    logic          wr_en_s;
    logic [1:0]    wr_be_s;
    logic          debug_unused_s;

    assign cmd_valid_s   = bus.cke & ~bus.cs_n;
    assign cmd_s         = cmd_e'({bus.ras_n, bus.cas_n, bus.we_n});
    assign rdwr_ok_s     = bank_open_q[bus.ba] & (rd_state_q == ENG_IDLE) & (wr_state_q == ENG_IDLE);
    assign rd_off_s      = rd_tick_q - RD_FIRST;
    assign wr_off_s      = wr_tick_q - WR_FIRST;
    assign rd_full_idx_s = {rd_base_q, rd_off_s[2:0]};
    assign wr_full_idx_s = {wr_base_q, wr_off_s[2:0]};
    assign wr_idx_s      = wr_full_idx_s[MEM_BITS-1:0];

`ifdef DDR3_BURST_MEM_DM_EN
    assign wr_be_s = ~bus.dm;
`else
    assign wr_be_s = 2'b11;
`endif

    // Aliased upper address bits, beat offset high bits and the trace hook are
    // deliberately not consumed.
    assign debug_unused_s = ^{rd_full_idx_s, wr_full_idx_s, rd_off_s, wr_off_s, bus.dm, (DEBUG != 0)};

    assign bus.dq_o  = dq_o_q;
    assign bus.dq_oe = dq_oe_q;
    assign bus.err   = err_q;

    // Next state: burst engines, bank table, command decode and outputs.
    always_comb begin
        bank_open_d = bank_open_q;
        bank_row_d  = bank_row_q;
        rd_state_d  = rd_state_q;
        rd_tick_d   = rd_tick_q;
        rd_base_d   = rd_base_q;
        wr_state_d  = wr_state_q;
        wr_tick_d   = wr_tick_q;
        wr_base_d   = wr_base_q;
        dq_o_d      = 16'h0000;
        dq_oe_d     = 1'b0;
        err_d       = 1'b0;
        wr_en_s     = 1'b0;

        if (rd_state_q == ENG_BUSY) begin
            if (rd_tick_q >= RD_FIRST) begin
                dq_o_d  = mem_q[rd_full_idx_s[MEM_BITS-1:0]];
                dq_oe_d = 1'b1;
            end else begin
                dq_oe_d = 1'b0;
            end
            if (rd_tick_q == RD_LAST) begin
                rd_state_d = ENG_IDLE;
            end else begin
                rd_tick_d = rd_tick_q + 5'd1;
            end
        end else begin
            rd_tick_d = 5'd0;
        end

        if (wr_state_q == ENG_BUSY) begin
            if (wr_tick_q >= WR_FIRST) begin
                wr_en_s = 1'b1;
            end else begin
                wr_en_s = 1'b0;
            end
            if (wr_tick_q == WR_LAST) begin
                wr_state_d = ENG_IDLE;
            end else begin
                wr_tick_d = wr_tick_q + 5'd1;
            end
        end else begin
            wr_tick_d = 5'd0;
        end

        // A new RD/WR is only accepted with both engines idle, so it never
        // collides with the engine updates above.
        if (cmd_valid_s) begin
            case (cmd_s)
                CMD_ACT: begin
                    if (bank_open_q[bus.ba]) begin
                        err_d = 1'b1;
                    end else begin
                        bank_open_d[bus.ba] = 1'b1;
                        bank_row_d[bus.ba]  = bus.addr;
                    end
                end
                CMD_PRE: begin
                    if (bus.addr[10]) begin
                        bank_open_d = 8'h00;
                    end else begin
                        bank_open_d[bus.ba] = 1'b0;
                    end
                end
                CMD_REF, CMD_MRS: begin
                    if (bank_open_q != 8'h00) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                    end
                end
                CMD_RD: begin
                    if (rdwr_ok_s) begin
                        rd_state_d = ENG_BUSY;
                        rd_tick_d  = 5'd1;
                        rd_base_d  = {bus.ba, bank_row_q[bus.ba], bus.addr[9:3]};
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_WR: begin
                    if (rdwr_ok_s) begin
                        wr_state_d = ENG_BUSY;
                        wr_tick_d  = 5'd1;
                        wr_base_d  = {bus.ba, bank_row_q[bus.ba], bus.addr[9:3]};
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    err_d = 1'b0;
                end
            endcase
        end else begin
            err_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bank_open_q <= 8'h00;
            bank_row_q  <= '{default: 15'd0};
            rd_state_q  <= ENG_IDLE;
            rd_tick_q   <= 5'd0;
            rd_base_q   <= 25'd0;
            wr_state_q  <= ENG_IDLE;
            wr_tick_q   <= 5'd0;
            wr_base_q   <= 25'd0;
            dq_o_q      <= 16'h0000;
            dq_oe_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bank_open_q <= bank_open_d;
            bank_row_q  <= bank_row_d;
            rd_state_q  <= rd_state_d;
            rd_tick_q   <= rd_tick_d;
            rd_base_q   <= rd_base_d;
            wr_state_q  <= wr_state_d;
            wr_tick_q   <= wr_tick_d;
            wr_base_q   <= wr_base_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            err_q       <= err_d;
        end
    end

    // Storage array: not reset; a reset edge suppresses the pending write beat.
    always_ff @(posedge sys_clk) begin
        if (wr_en_s && !sys_rst) begin
            if (wr_be_s[0]) begin
                mem_q[wr_idx_s][7:0] <= bus.dq_i[7:0];
            end
            if (wr_be_s[1]) begin
                mem_q[wr_idx_s][15:8] <= bus.dq_i[15:8];
            end
        end
    end
endmodule

// File: tb/tb_ddr3_burst_mem.sv
// -----------------------------------------------------------------------------
// tb_ddr3_burst_mem
// Directed scenarios followed by randomized command traffic. A transaction
// level reference model (bank table, scheduled beat queues, sparse memory)
// predicts err, dq_oe and dq_o for every clock.
// -----------------------------------------------------------------------------
module tb_ddr3_burst_mem;
    localparam int MEM_BITS = 18;
    localparam int CL       = 5;
    localparam int CWL      = 5;

    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_MRS = 3'b000;
    localparam logic [2:0] C_ZQ  = 3'b110;

    logic sys_clk = 1'b0;
    logic sys_rst;

    ddr3_burst_mem_if bus ();

    ddr3_burst_mem #(
        .MEM_BITS (MEM_BITS),
        .CL       (CL),
        .CWL      (CWL),
        .DEBUG    (0)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          at;
        int          idx;
        logic [15:0] data;
    } beat_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          edge_n  = 0;
    logic [7:0]  m_open;
    logic [14:0] m_row [8];
    int          rd_busy_until;
    int          wr_busy_until;
    beat_t       rq[$];
    beat_t       wq[$];
    logic [15:0] mm [int];
    logic        exp_err, exp_oe;
    logic [15:0] exp_dq;
    logic        obs_err, obs_oe;
    logic [15:0] obs_dq;
    logic [15:0] got_beats [8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, edge_n, got, exp);
        end
    endtask

    function automatic int word_idx(input logic [2:0] b, input logic [14:0] row,
                                    input logic [14:0] a, input int k);
        longint w;
        w = (longint'(b) << 25) + (longint'(row) << 10) + (longint'((a >> 3) & 15'h007F) << 3) + longint'(k);
        return int'(w % (longint'(1) << MEM_BITS));
    endfunction

    function automatic logic [15:0] mem_read(input int i);
        if (mm.exists(i)) return mm[i];
        return 16'h0000;
    endfunction

    // Reference model: advance one clock edge using the inputs present at it.
    task automatic model_edge();
        beat_t       b;
        logic [15:0] w;
        edge_n++;
        exp_err = 1'b0;
        exp_oe  = 1'b0;
        exp_dq  = 16'h0000;
        if (sys_rst) begin
            m_open = 8'h00;
            rq.delete();
            wq.delete();
            rd_busy_until = -1;
            wr_busy_until = -1;
        end else begin
            if (wq.size() > 0 && wq[0].at == edge_n) begin
                b = wq.pop_front();
                w = mem_read(b.idx);
`ifdef DDR3_BURST_MEM_DM_EN
                if (!bus.dm[0]) w[7:0] = bus.dq_i[7:0];
                if (!bus.dm[1]) w[15:8] = bus.dq_i[15:8];
`else
                w = bus.dq_i;
`endif
                mm[b.idx] = w;
            end
            if (rq.size() > 0 && rq[0].at == edge_n) begin
                b = rq.pop_front();
                exp_oe = 1'b1;
                exp_dq = b.data;
            end
            if (bus.cke && !bus.cs_n) begin
                case ({bus.ras_n, bus.cas_n, bus.we_n})
                    C_ACT: begin
                        if (m_open[bus.ba]) exp_err = 1'b1;
                        else begin
                            m_open[bus.ba] = 1'b1;
                            m_row[bus.ba]  = bus.addr;
                        end
                    end
                    C_PRE: begin
                        if (bus.addr[10]) m_open = 8'h00;
                        else m_open[bus.ba] = 1'b0;
                    end
                    C_REF, C_MRS: begin
                        if (m_open != 8'h00) exp_err = 1'b1;
                    end
                    C_RD, C_WR: begin
                        if (!m_open[bus.ba] || edge_n <= rd_busy_until || edge_n <= wr_busy_until) begin
                            exp_err = 1'b1;
                        end else if (bus.we_n) begin
                            for (int k = 0; k < 8; k++) begin
                                b.at   = edge_n + CL + k;
                                b.idx  = word_idx(bus.ba, m_row[bus.ba], bus.addr, k);
                                b.data = mem_read(b.idx);
                                rq.push_back(b);
                            end
                            rd_busy_until = edge_n + CL + 7;
                        end else begin
                            for (int k = 0; k < 8; k++) begin
                                b.at   = edge_n + CWL + k;
                                b.idx  = word_idx(bus.ba, m_row[bus.ba], bus.addr, k);
                                b.data = 16'h0000;
                                wq.push_back(b);
                            end
                            wr_busy_until = edge_n + CWL + 7;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // One clock: model at the rising edge, compare on the falling edge.
    task automatic cycle();
        @(posedge sys_clk);
        model_edge();
        @(negedge sys_clk);
        obs_err = bus.err;
        obs_oe  = bus.dq_oe;
        obs_dq  = bus.dq_o;
        check_eq("err", {31'd0, obs_err}, {31'd0, exp_err});
        check_eq("dq_oe", {31'd0, obs_oe}, {31'd0, exp_oe});
        check_eq("dq_o", {16'd0, obs_dq}, {16'd0, exp_dq});
    endtask

    task automatic set_cmd(input logic [2:0] c, input logic [2:0] b, input logic [14:0] a);
        bus.cs_n = (c == C_NOP);
        {bus.ras_n, bus.cas_n, bus.we_n} = c;
        bus.ba   = b;
        bus.addr = a;
    endtask

    task automatic issue(input logic [2:0] c, input logic [2:0] b, input logic [14:0] a);
        set_cmd(c, b, a);
        cycle();
        set_cmd(C_NOP, 3'd0, 15'd0);
    endtask

    // WR burst: beat k = base+k, except beat sp which carries sp_d with mask sp_m.
    task automatic wr_burst(input logic [2:0] b, input logic [14:0] a, input logic [15:0] base,
                            input int sp, input logic [15:0] sp_d, input logic [1:0] sp_m);
        issue(C_WR, b, a);
        for (int e = 1; e <= CWL + 7; e++) begin
            if (e >= CWL) begin
                if (e - CWL == sp) begin
                    bus.dq_i = sp_d;
                    bus.dm   = sp_m;
                end else begin
                    bus.dq_i = base + 16'(e - CWL);
                    bus.dm   = 2'b00;
                end
            end else begin
                bus.dq_i = 16'($urandom);
                bus.dm   = 2'($urandom);
            end
            cycle();
        end
        bus.dm = 2'b00;
    endtask

    // RD burst: captures the eight beats and checks the dq_oe window.
    task automatic rd_collect(input logic [2:0] b, input logic [14:0] a);
        issue(C_RD, b, a);
        for (int e = 1; e <= CL + 8; e++) begin
            cycle();
            check_eq("rd_window", {31'd0, obs_oe}, {31'd0, (e >= CL && e <= CL + 7)});
            if (e >= CL && e <= CL + 7) got_beats[e - CL] = obs_dq;
        end
    endtask

    initial begin
        logic [15:0] beat3_exp;
        int          r;
`ifdef DDR3_BURST_MEM_DM_EN
        beat3_exp = 16'h10CD;
`else
        beat3_exp = 16'hABCD;
`endif
        m_open        = 8'h00;
        rd_busy_until = -1;
        wr_busy_until = -1;
        bus.cke  = 1'b1;
        bus.dm   = 2'b00;
        bus.dq_i = 16'h0000;
        set_cmd(C_NOP, 3'd0, 15'd0);
        sys_rst = 1'b1;
        repeat (3) cycle();
        check_eq("rst_dq_oe", {31'd0, obs_oe}, 32'd0);
        check_eq("rst_err", {31'd0, obs_err}, 32'd0);
        check_eq("rst_dq_o", {16'd0, obs_dq}, 32'd0);
        sys_rst = 1'b0;
        cycle();

        // Basic write then read-back.
        issue(C_ACT, 3'd1, 15'h0123);
        wr_burst(3'd1, 15'h0010, 16'h1000, 8, 16'h0000, 2'b00);
        rd_collect(3'd1, 15'h0010);
        for (int k = 0; k < 8; k++) check_eq("tp1_beat", {16'd0, got_beats[k]}, {16'd0, 16'h1000 + 16'(k)});

        // RD to an idle bank, ACT to an open bank.
        issue(C_RD, 3'd2, 15'h0010);
        check_eq("rd_idle_err", {31'd0, obs_err}, 32'd1);
        check_eq("rd_idle_oe", {31'd0, obs_oe}, 32'd0);
        cycle();
        check_eq("err_one_cycle", {31'd0, obs_err}, 32'd0);
        issue(C_ACT, 3'd1, 15'h0055);
        check_eq("act_open_err", {31'd0, obs_err}, 32'd1);
        cycle();

        // Byte mask on beat 3.
        wr_burst(3'd1, 15'h0010, 16'h1000, 3, 16'hABCD, 2'b10);
        rd_collect(3'd1, 15'h0010);
        check_eq("dm_beat3", {16'd0, got_beats[3]}, {16'd0, beat3_exp});
        check_eq("dm_beat2", {16'd0, got_beats[2]}, 32'h1002);

        // Second RD during an active burst is rejected.
        issue(C_RD, 3'd1, 15'h0010);
        for (int e = 1; e <= CL + 8; e++) begin
            if (e == CL + 2) set_cmd(C_RD, 3'd1, 15'h0018);
            cycle();
            if (e == CL + 2) begin
                check_eq("rd_busy_err", {31'd0, obs_err}, 32'd1);
                set_cmd(C_NOP, 3'd0, 15'd0);
            end
            if (e >= CL && e <= CL + 7) got_beats[e - CL] = obs_dq;
        end
        for (int k = 0; k < 8; k++)
            check_eq("busy_beats", {16'd0, got_beats[k]}, {16'd0, (k == 3) ? beat3_exp : 16'h1000 + 16'(k)});
        check_eq("burst_end_oe", {31'd0, obs_oe}, 32'd0);

        // PRE all, REF/MRS legality.
        issue(C_PRE, 3'd0, 15'h0400);
        check_eq("pre_all_err", {31'd0, obs_err}, 32'd0);
        issue(C_REF, 3'd0, 15'h0000);
        check_eq("ref_idle_err", {31'd0, obs_err}, 32'd0);
        issue(C_ACT, 3'd4, 15'h7FFF);
        issue(C_REF, 3'd0, 15'h0000);
        check_eq("ref_open_err", {31'd0, obs_err}, 32'd1);
        issue(C_MRS, 3'd0, 15'h0000);
        check_eq("mrs_open_err", {31'd0, obs_err}, 32'd1);

        // Never-written location, then write it and reset mid-read.
        rd_collect(3'd4, 15'h03F8);
        check_eq("unwritten_rd", {16'd0, got_beats[0]}, 32'd0);
        wr_burst(3'd4, 15'h03F8, 16'hC000, 8, 16'h0000, 2'b00);
        issue(C_RD, 3'd4, 15'h03F8);
        for (int e = 1; e <= CL + 2; e++) cycle();
        check_eq("pre_rst_oe", {31'd0, obs_oe}, 32'd1);
        sys_rst = 1'b1;
        cycle();
        check_eq("rst_mid_oe", {31'd0, obs_oe}, 32'd0);
        check_eq("rst_mid_dq", {16'd0, obs_dq}, 32'd0);
        sys_rst = 1'b0;
        cycle();
        issue(C_RD, 3'd4, 15'h03F8);
        check_eq("rd_after_rst_err", {31'd0, obs_err}, 32'd1);
        issue(C_ACT, 3'd4, 15'h7FFF);
        rd_collect(3'd4, 15'h03F8);
        check_eq("mem_kept_rst", {16'd0, got_beats[7]}, 32'hC007);
        issue(C_PRE, 3'd0, 15'h0400);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            sys_rst   = ($urandom_range(0, 399) == 0);
            bus.cke   = ($urandom_range(0, 9) != 0);
            bus.dq_i  = 16'($urandom);
            bus.dm    = 2'($urandom);
            if (r < 40)      set_cmd(C_NOP, 3'($urandom_range(0, 3)), 15'($urandom));
            else if (r < 55) set_cmd(C_ACT, 3'($urandom_range(0, 3)), 15'($urandom_range(0, 3)));
            else if (r < 65) set_cmd(C_PRE, 3'($urandom_range(0, 3)),
                                     {4'd0, ($urandom_range(0, 3) == 0), 10'($urandom)});
            else if (r < 80) set_cmd(C_WR, 3'($urandom_range(0, 3)), 15'($urandom_range(0, 31)));
            else if (r < 95) set_cmd(C_RD, 3'($urandom_range(0, 3)), 15'($urandom_range(0, 31)));
            else if (r < 97) set_cmd(C_REF, 3'd0, 15'd0);
            else if (r < 98) set_cmd(C_MRS, 3'd0, 15'd0);
            else             set_cmd(C_ZQ, 3'd0, 15'd0);
            if ($urandom_range(0, 9) == 0) bus.cs_n = 1'b1;
            cycle();
        end
        sys_rst = 1'b0;
        bus.cke = 1'b1;
        set_cmd(C_NOP, 3'd0, 15'd0);
        repeat (CL + CWL + 10) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
